// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule stage.
//
// Loads the cipher key on kld and then produces one round key per clock,
// four 32-bit words at a time, until round key ROUNDS is reached. The
// round constant comes from aes_rcon, which is strobed by the same kld.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   kld        key load strobe (shared with aes_rcon.kld)
//   key[127:0] cipher key, key[127:96] is word 0
//   rcon[31:0] round constant from aes_rcon.out
//   wo_0..wo_3 current round key words (registered)
//   round      index of the round key on wo_*
//   key_valid  wo_* holds a valid round key
//   done       round key ROUNDS is on wo_*

// Byte substitution lookup (forward AES S-box).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  // Index 0 is the leftmost entry.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign d = SBOX[a];
endmodule

module aes_key_expand_128 #(
  parameter int unsigned ROUNDS = 10  // 1..10, bounded by the rcon sequence
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic [31:0]  rcon,
  output logic [31:0]  wo_0,
  output logic [31:0]  wo_1,
  output logic [31:0]  wo_2,
  output logic [31:0]  wo_3,
  output logic [3:0]   round,
  output logic         key_valid,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [3:0]  round_q;
  logic        valid_q, done_q;

  // ---- next round key (combinational) ----
  logic [31:0] rot, sub, t, n0, n1, n2, n3;

  assign rot = {w3_q[23:0], w3_q[31:24]};  // RotWord

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .d(sub[8*i +: 8]));
  end

  // rcon belongs to the current round: aes_rcon was loaded on the same kld edge.
  assign t  = sub ^ rcon;
  assign n0 = w0_q ^ t;
  assign n1 = w1_q ^ n0;
  assign n2 = w2_q ^ n1;
  assign n3 = w3_q ^ n2;

  // ---- FSM ----
  logic last_step, load, step;

  assign last_step = (round_q == 4'(ROUNDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kld) state_d = RUN;
    else begin
      case (state_q)
        RUN:     if (last_step) state_d = HOLD;
        default: state_d = state_q;  // IDLE and HOLD wait for kld
      endcase
    end
  end

  // kld wins in every state, so a reload mid-expansion discards the schedule.
  always_comb begin
    load = kld;
    step = !kld && (state_q == RUN);
  end

  // ---- datapath registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      w0_q    <= key[127:96];
      w1_q    <= key[95:64];
      w2_q    <= key[63:32];
      w3_q    <= key[31:0];
      round_q <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (step) begin
      w0_q    <= n0;
      w1_q    <= n1;
      w2_q    <= n2;
      w3_q    <= n3;
      round_q <= round_q + 4'd1;
      done_q  <= last_step;
    end
  end

  assign wo_0      = w0_q;
  assign wo_1      = w1_q;
  assign wo_2      = w2_q;
  assign wo_3      = w3_q;
  assign round     = round_q;
  assign key_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  rcon;
  logic [31:0]  wo_0, wo_1, wo_2, wo_3;
  logic [3:0]   round;
  logic         key_valid, done;

  aes_key_expand_128 #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .rcon(rcon),
    .wo_0(wo_0), .wo_1(wo_1), .wo_2(wo_2), .wo_3(wo_3),
    .round(round), .key_valid(key_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Upstream aes_rcon model: 01 on the kld edge, then xtime each clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rcon <= '0;
    else if (kld) rcon <= 32'h0100_0000;
    else          rcon <= {(rcon[31] ? ({rcon[30:24], 1'b0} ^ 8'h1b) : {rcon[30:24], 1'b0}), 24'h0};
  end

  localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] K2_R1  = 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;

  // FIPS-197 Appendix A.1 round keys for K1.
  function automatic logic [127:0] rk1(input int r);
    case (r)
      0:  rk1 = K1;
      1:  rk1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
      2:  rk1 = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
      3:  rk1 = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
      4:  rk1 = 128'hef44a541_a8525b7f_b671253b_db0bad00;
      5:  rk1 = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
      6:  rk1 = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
      7:  rk1 = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
      8:  rk1 = 128'head27321_b58dbad2_312bf560_7f8d292f;
      9:  rk1 = 128'hac7766f3_19fadc21_28d12941_575c006e;
      default: rk1 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    endcase
  endfunction

  typedef struct packed {
    logic         cw;   // compare the key words too
    logic [127:0] w;
    logic [3:0]   rnd;
    logic         v;
    logic         d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t mk(input logic cw, input logic [127:0] w,
                              input int r, input logic v, input logic d);
    mk = '{cw: cw, w: w, rnd: 4'(r), v: v, d: d};
  endfunction

  // Active edge, then settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [127:0] w;
    rst = 1'b0; kld = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(mk(1, '0, 0, 0, 0));
    tick(); tick();
    e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
      failures++;
      $display("FAIL reset_held got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", w, round, key_valid, done, e.w, e.rnd, e.v, e.d);
    end
    kld = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, '0, 0, 0, 0));
      tick();
      e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", i, w, round, key_valid, done, e.w, e.rnd, e.v, e.d);
      end
    end
  endtask

  // Load K1, expand all 10 rounds, then hold for 5 cycles.
  task automatic test_fips_schedule();
    exp_t e;
    logic [127:0] w;
    kld = 1'b1; key = K1;
    sb.push_back(mk(1, K1, 0, 1, 0));
    tick();
    kld = 1'b0; key = '0;
    for (int r = 1; r <= 15; r++) sb.push_back(mk(1, rk1(r > 10 ? 10 : r), r > 10 ? 10 : r, 1, r >= 10));
    for (int r = 0; r <= 15; r++) begin
      if (r > 0) tick();
      e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
        failures++;
        $display("FAIL fips_step%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", r, w, round, key_valid, done, e.w, e.rnd, e.v, e.d);
      end
    end
  endtask

  // Run K1 to round 4, then reload with K2 and expand it fully.
  task automatic test_restart();
    exp_t e;
    logic [127:0] w;
    logic ok;
    kld = 1'b1; key = K1;
    tick();
    kld = 1'b0;
    repeat (4) tick();
    checks++;
    if (round !== 4'd4 || {wo_0, wo_1, wo_2, wo_3} !== rk1(4)) begin
      failures++;
      $display("FAIL restart_pre got=%0d/%h exp=4/%h", round, {wo_0, wo_1, wo_2, wo_3}, rk1(4));
    end
    kld = 1'b1; key = K2;
    sb.push_back(mk(1, K2, 0, 1, 0));
    tick();
    kld = 1'b0;
    for (int r = 1; r <= 10; r++)
      sb.push_back(mk(r == 1 || r == 10, r == 1 ? K2_R1 : (r == 10 ? K2_R10 : '0), r, 1, r == 10));
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) tick();
      e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
      ok = ({round, key_valid, done} === {e.rnd, e.v, e.d}) && (!e.cw || w === e.w);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL restart_step%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", r, w, round, key_valid, done, e.w, e.rnd, e.v, e.d);
      end
    end
  endtask

  // Reset asserted between edges at round 6 must clear without a clock.
  task automatic test_async_reset();
    exp_t e;
    logic [127:0] w;
    kld = 1'b1; key = K1;
    tick();
    kld = 1'b0;
    repeat (6) tick();
    checks++;
    if (round !== 4'd6 || {wo_0, wo_1, wo_2, wo_3} !== rk1(6)) begin
      failures++;
      $display("FAIL async_pre got=%0d/%h exp=6/%h", round, {wo_0, wo_1, wo_2, wo_3}, rk1(6));
    end
    #2 rst = 1'b0;
    sb.push_back(mk(1, '0, 0, 0, 0));
    #1;
    e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
      failures++;
      $display("FAIL async_clear got=%h/%0d/%b/%b exp=0/0/0/0", w, round, key_valid, done);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, '0, 0, 0, 0));
      tick();
      e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
        failures++;
        $display("FAIL async_idle cyc=%0d got=%h/%0d/%b/%b exp=0/0/0/0", i, w, round, key_valid, done);
      end
    end
  endtask

  // kld held 3 cycles: stays at round 0; the first low edge gives round 1.
  task automatic test_kld_held();
    exp_t e;
    logic [127:0] w;
    kld = 1'b1; key = K2;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1, K2, 0, 1, 0));
      tick();
      e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d} || rcon !== 32'h0100_0000) begin
        failures++;
        $display("FAIL kld_held cyc=%0d got=%h/%0d/%b/%b rcon=%h exp=%h/0/1/0 rcon=01000000", i, w, round, key_valid, done, rcon, e.w);
      end
    end
    kld = 1'b0;
    sb.push_back(mk(1, K2_R1, 1, 1, 0));
    tick();
    e = sb.pop_front(); w = {wo_0, wo_1, wo_2, wo_3};
    checks++;
    if ({w, round, key_valid, done} !== {e.w, e.rnd, e.v, e.d}) begin
      failures++;
      $display("FAIL kld_held_r1 got=%h/%0d/%b/%b exp=%h/1/1/0", w, round, key_valid, done, e.w);
    end
  endtask

  initial begin
    rst = 1'b0; kld = 1'b0; key = '0;
    test_reset();
    test_fips_schedule();
    test_restart();
    test_async_reset();
    test_kld_held();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_128.md
Name: aes_key_expand_128

Overview:
- AES-128 key schedule stage, directly downstream of aes_rcon; consumes its 32-bit round constant on the same kld strobe.
- Produces one 128-bit round key per clock, as four 32-bit words, for the cipher round datapath.
- Holds round key 0 after load, then advances one round per cycle through round key ROUNDS, then freezes.
- Instantiates four existing aes_sbox lookups for SubWord.

Parameters:
ROUNDS, 10, number of expansion steps after load; legal range 1..10; the rcon sequence limits it to 10.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
kld  input  1  key load strobe; same signal that drives aes_rcon.kld
key  input  128  cipher key; key[127:96] is word 0
rcon  input  32  round constant from aes_rcon.out
wo_0  output  32  round key word 0
wo_1  output  32  round key word 1
wo_2  output  32  round key word 2
wo_3  output  32  round key word 3
round  output  4  index of the round key currently on wo_*
key_valid  output  1  wo_* holds a valid round key
done  output  1  final round key (index ROUNDS) is on wo_*

Behaviour:
- Reset (rst=0, asynchronous, takes priority over everything): wo_0..wo_3=0, round=0, key_valid=0, done=0. Reset held low makes the block ignore kld.
- Internal FSM states:
  - IDLE: state after reset, before any kld.
  - RUN: round < ROUNDS.
  - HOLD: round = ROUNDS.
- kld=1 at a rising edge, in any state:
  - w0..w3 <= key[127:96], key[95:64], key[63:32], key[31:0].
  - round <= 0; key_valid <= 1; done <= 0; state <= RUN.
  - Load latency: 1 clock.
- RUN with kld=0 at each edge:
  - t = SubWord(RotWord(w3)) ^ rcon. RotWord(a,b,c,d) = (b,c,d,a). SubWord applies aes_sbox to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - round <= round+1.
  - If round+1 == ROUNDS: done <= 1, state <= HOLD.
- Rcon alignment: aes_rcon registers 0x01000000 on the same kld edge, then 02,04,08,10,20,40,80,1b,36. The step from round k to k+1 therefore uses the rcon value present during round k. No extra pipelining is allowed.
- HOLD with kld=0: all outputs frozen; rcon ignored.
- IDLE with kld=0: outputs stay at reset values.
- kld mid-expansion (RUN): restarts from the new key immediately. The partial schedule is discarded.
- kld held high for several cycles: reloads every cycle; round stays 0. Expansion starts on the first edge with kld=0.
- Datapath is combinational SubWord feeding registers. All outputs are registered directly.

Test Plan:
- Reset: rst=0 with kld=1 and arbitrary key -> wo_*=0, round=0, key_valid=0, done=0. Release rst with kld=0 -> outputs stay 0.
- FIPS-197 load: key=2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse kld for one cycle:
  - 1 edge later: wo=key, round=0, key_valid=1.
  - next edge: a0fafe17 88542cb1 23a33939 2a6c7605, round=1.
  - next edge: f2c295f2 7a96b943 5935807a 7359f67f, round=2.
- Full schedule from the same key: after 10 steps -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6, round=10, done=1. Five more cycles with kld=0 -> all outputs unchanged.
- Restart mid-expansion: at round=4, pulse kld with key=000102030405060708090a0b0c0d0e0f:
  - -> round=0, done=0, wo=key.
  - next edge: d6aa74fd d2af72fa daa678f1 d6ab76fe.
  - after 10 steps: 13111d7f e3944a17 f307a78b 4d2b30c5.
- Asynchronous reset at round=6, asserted between clock edges -> outputs clear immediately without a clock edge. After release, block stays IDLE until the next kld.
- kld held high for 3 cycles -> round=0 throughout and wo=key. The first edge with kld=0 yields the round-1 key, cross-checked against the aes_rcon output sequence.
